// File: rtl/ps2_key_display.sv
//------------------------------------------------------------------------------
// Module   : ps2_key_display
// Brief    : PS/2 scan-code decoder with held-key and BCD press-count displays
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_key_display #(
    parameter int CNT_DIGITS         = 2,
    parameter bit BLANK_ON_RELEASE   = 1'b1,
    parameter bit LEADING_ZERO_BLANK = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                kb_data,
    input  logic                      kb_ready,
    input  logic                      kb_overflow,
    output logic                      kb_next,
    output logic                      key_down,
    output logic                      key_ext,
    output logic                      ovf_seen,
    output logic [15:0]               hex_code,
    output logic [8*CNT_DIGITS-1:0]   hex_cnt
);

    localparam int         c_CNT_W = 4 * CNT_DIGITS;
    localparam logic [7:0] c_PFX_EXT = 8'hE0;
    localparam logic [7:0] c_PFX_BRK = 8'hF0;

    function automatic logic [6:0] f_seg7(input logic [3:0] n);
        case (n)
            4'h0: f_seg7 = 7'h40;  4'h1: f_seg7 = 7'h79;
            4'h2: f_seg7 = 7'h24;  4'h3: f_seg7 = 7'h30;
            4'h4: f_seg7 = 7'h19;  4'h5: f_seg7 = 7'h12;
            4'h6: f_seg7 = 7'h02;  4'h7: f_seg7 = 7'h78;
            4'h8: f_seg7 = 7'h00;  4'h9: f_seg7 = 7'h10;
            4'hA: f_seg7 = 7'h08;  4'hB: f_seg7 = 7'h03;
            4'hC: f_seg7 = 7'h46;  4'hD: f_seg7 = 7'h21;
            4'hE: f_seg7 = 7'h06;  default: f_seg7 = 7'h0E;
        endcase
    endfunction

    // Count display for a zero count: digit 0 always shows "0"
    function automatic logic [8*CNT_DIGITS-1:0] f_cnt_rst();
        logic [8*CNT_DIGITS-1:0] v;
        for (int i = 0; i < CNT_DIGITS; i++) begin
            v[8*i +: 8] = (LEADING_ZERO_BLANK && i != 0) ? 8'hFF : 8'hC0;
        end
        return v;
    endfunction

    logic                    r_kb_next;
    logic                    r_brk;
    logic                    r_ext;
    logic [7:0]              r_code;
    logic                    r_key_down;
    logic                    r_key_ext;
    logic                    r_ovf;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [15:0]             r_hex_code;
    logic [8*CNT_DIGITS-1:0] r_hex_cnt;

    logic                    w_accept;
    logic                    w_carry;
    logic                    w_zero_above;
    logic [c_CNT_W-1:0]      w_cnt_inc;
    logic [15:0]             w_hex_code;
    logic [8*CNT_DIGITS-1:0] w_hex_cnt;

    assign w_accept = kb_ready && !r_kb_next;

    always_comb begin
        w_cnt_inc = r_cnt;
        w_carry   = 1'b1;
        for (int i = 0; i < CNT_DIGITS; i++) begin
            if (w_carry) begin
                if (r_cnt[4*i +: 4] == 4'd9) begin
                    w_cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    // Walk from the most significant digit so zeros count as leading only
    // while every digit above them is also zero.
    always_comb begin
        w_hex_cnt    = '1;
        w_zero_above = 1'b1;
        for (int i = CNT_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_cnt[4*i +: 4] == 4'd0);
            if (LEADING_ZERO_BLANK && i != 0 && w_zero_above) begin
                w_hex_cnt[8*i +: 8] = 8'hFF;
            end else begin
                w_hex_cnt[8*i +: 8] = {1'b1, f_seg7(r_cnt[4*i +: 4])};
            end
        end
        w_hex_cnt[7] = ~r_ovf;
    end

    always_comb begin
        if (r_key_down) begin
            w_hex_code = {~r_key_ext, f_seg7(r_code[7:4]), 1'b1, f_seg7(r_code[3:0])};
        end else if (BLANK_ON_RELEASE) begin
            w_hex_code = 16'hFFFF;
        end else begin
            w_hex_code = {1'b1, f_seg7(r_code[7:4]), 1'b1, f_seg7(r_code[3:0])};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kb_next  <= 1'b0;
            r_brk      <= 1'b0;
            r_ext      <= 1'b0;
            r_code     <= 8'h00;
            r_key_down <= 1'b0;
            r_key_ext  <= 1'b0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_hex_code <= 16'hFFFF;
            r_hex_cnt  <= f_cnt_rst();
        end else begin
            r_kb_next  <= w_accept;
            r_hex_code <= w_hex_code;
            r_hex_cnt  <= w_hex_cnt;
            if (kb_overflow) begin
                r_ovf <= 1'b1;
            end
            if (w_accept) begin
                if (kb_data == c_PFX_EXT) begin
                    r_ext <= 1'b1;
                end else if (kb_data == c_PFX_BRK) begin
                    r_brk <= 1'b1;
                end else if (r_brk) begin
                    // Releases of anything other than the held key are ignored
                    if (kb_data == r_code && r_ext == r_key_ext) begin
                        r_key_down <= 1'b0;
                    end
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end else if (r_key_down && kb_data == r_code && r_ext == r_key_ext) begin
                    r_ext <= 1'b0;
                end else begin
                    r_code     <= kb_data;
                    r_key_ext  <= r_ext;
                    r_key_down <= 1'b1;
                    r_cnt      <= w_cnt_inc;
                    r_ext      <= 1'b0;
                end
            end
        end
    end

    assign kb_next  = r_kb_next;
    assign key_down = r_key_down;
    assign key_ext  = r_key_ext;
    assign ovf_seen = r_ovf;
    assign hex_code = r_hex_code;
    assign hex_cnt  = r_hex_cnt;

endmodule

`default_nettype wire

// File: doc/ps2_key_display.md
Name: ps2_key_display

Overview:
- Successor to the two-digit PS/2 scan-code display top level.
- Consumes the byte stream from the PS/2 receiver through a ready/next handshake.
- Decodes make, break (F0) and extended (E0) sequences, holds the currently pressed key and suppresses typematic repeats.
- Drives active-low seven-segment digits for the held scan code and a parametrised BCD count of key presses.

Parameters:
- CNT_DIGITS, 2, number of BCD digits in the press counter (1..4); counter wraps at 10^CNT_DIGITS.
- BLANK_ON_RELEASE, 1, 1 = code digits blank when no key is held; 0 = last code stays displayed.
- LEADING_ZERO_BLANK, 0, 1 = blank leading zeros of the count (digit 0 always shown).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- kb_data  input  8  byte at head of the receiver FIFO
- kb_ready  input  1  level; kb_data is valid
- kb_overflow  input  1  receiver FIFO overflow, level
- kb_next  output  1  one-cycle pop strobe to the receiver
- key_down  output  1  a key is currently held
- key_ext  output  1  held key is an E0-extended key
- ovf_seen  output  1  sticky overflow flag
- hex_code  output  16  segments; [7:0] = low nibble of code, [15:8] = high nibble
- hex_cnt  output  8*CNT_DIGITS  segments; [7:0] = least significant count digit

Behaviour:
- Clocking and reset: single clock; every register resets synchronously when rst=1 at a rising edge.
- Values after reset:
  - kb_next=0, key_down=0, key_ext=0, ovf_seen=0.
  - Pending E0/F0 flags cleared; held code=8'h00; count=0.
  - hex_code=16'hFFFF.
  - hex_cnt shows digit 0 as "0"; other digits show "0", or 8'hFF if LEADING_ZERO_BLANK=1.
- Reset mid-sequence discards any pending E0/F0 prefix.
- Segment encoding, per 8-bit digit:
  - Bits [6:0] = g..a, active-low; bit 7 = dp, active-low.
  - Blank = 8'hFF; hex values 0..F use the standard hex glyphs.
- Handshake:
  - Accept at edge E when kb_ready=1 and kb_next=0; kb_data is decoded at that edge.
  - kb_next=1 for exactly the cycle after E, then 0.
  - Hence at most one byte per two cycles, and no byte is accepted while kb_next=1.
  - kb_ready=0 means no action.
- Decode of an accepted byte, using pending flags brk/ext:
  - 8'hE0: set ext.
  - 8'hF0: set brk.
  - Other byte with brk=1 (release): if byte==held code and ext==key_ext, clear key_down. Otherwise the state is unchanged (stray release). Clear brk and ext.
  - Other byte with brk=0, key_down=1, byte==held code, ext==key_ext (typematic repeat): no change, count not incremented. Clear ext.
  - Other byte with brk=0 (new make): held code=byte, key_ext=ext, key_down=1, count += 1. Clear ext.
  - A new make while a different key is held replaces it (last key wins).
- Counter:
  - CNT_DIGITS-digit BCD, decimal carry per digit.
  - All-9s + 1 -> all-0s; wrap is silent.
- key_down, key_ext and the count update at edge E.
- hex_code and hex_cnt are registered from that state and update at edge E+1 (one-cycle display latency).
- hex_code:
  - key_down=1: glyphs of the held code; dp of [15:8] is lit (bit 15=0) when key_ext=1.
  - key_down=0: 16'hFFFF if BLANK_ON_RELEASE=1, else the last code with dp off.
- Overflow: kb_overflow=1 at any edge sets ovf_seen, which clears only on rst. ovf_seen=1 lights the dp of hex_cnt digit 0 (bit 7=0).
- Simultaneous rst and kb_ready: reset wins; the byte is not popped (kb_next stays 0).

Test Plan:
- Reset, then idle: hex_code=16'hFFFF, hex_cnt=16'hC0C0 (CNT_DIGITS=2, LEADING_ZERO_BLANK=0), kb_next=0.
- Sequence 1C, F0, 1C, each held on kb_ready until kb_next is seen:
  - After 1C: key_down=1, hex_code={seg(1),seg(C)}, count=01.
  - After F0 1C: key_down=0, hex_code=FFFF, count stays 01.
- Typematic 1C,1C,1C then F0,1C: count increments only once. kb_next pulses once per byte and is never high on consecutive cycles.
- Extended E0,75 then E0,F0,75: key_ext=1 and bit15=0 while held; the release clears key_down. A plain F0,75 while E0-75 is held does not release it.
- 100 distinct make/release pairs with CNT_DIGITS=2: count reads 99 -> 00 on the 100th make. With CNT_DIGITS=3 it reads 100.
- Reset after an E0/F0 prefix: send E0,F0, assert rst, then send 1C: make of non-extended 1C, count=1. A one-cycle kb_overflow pulse sets ovf_seen and hex_cnt bit7=0 until rst.
